pipelined_flag_alu: RTL and testbench
=====================================

Name: pipelined_flag_alu

Overview:
- Parametrised, registered successor to the processor's combinational datapath ALU.
- Implements the full ARM data-processing opcode set, including ADC/SBC/RSC, which carry in from an internal NZCV flag register.
- Adds a valid/ready handshake, a one-entry output register and an optional iterative multiplier.
- Sits between operand fetch/shifter and register writeback; the flags output feeds condition-code evaluation.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- MUL_CNT_W, 6, width of the multiply step counter; must satisfy 2^MUL_CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- data1  input  WIDTH  operand Rn, two's complement.
- data2  input  WIDTH  operand Op2, two's complement.
- operation  input  5  opcode: 00000 AND, 00001 EOR, 00010 SUB, 00011 RSB, 00100 ADD, 00101 ADC, 00110 SBC, 00111 RSC, 01000 TST, 01001 TEQ, 01010 CMP, 01011 CMN, 01100 ORR, 01101 MOV, 01110 BIC, 01111 MVN, 10000 MUL (optional).
- set_flags  input  1  S bit; flags update for non-compare ops only when 1.
- out_valid  output  1  result/writeback held valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- writeback  output  1  result must be written to Rd (0 for TST/TEQ/CMP/CMN/undefined).
- flags  output  4  registered CPSR bits: [0]=Z, [1]=C, [2]=N, [3]=V.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, result=0, writeback=0, flags=4'b0000, busy=0, FSM=IDLE, multiplier counter/accumulator cleared. Reset aborts an in-flight multiply and discards a held output.
- Accept: in_valid && in_ready at a clock edge. in_ready = (state==IDLE) && (!out_valid || out_ready), so an accept may coincide with an out_ready pop.
- Non-MUL ops: 1-cycle latency. result, writeback and out_valid=1 are registered at the accept edge. flags update at the same edge.
- Output hold: result and writeback stay stable while out_valid && !out_ready. out_valid clears on a pop with no simultaneous accept.
- Arithmetic is modulo 2^WIDTH with a (WIDTH+1)-bit internal sum.
  - ADD: a+b. ADC: a+b+C.
  - SUB/CMP: a+~b+1. SBC: a+~b+C.
  - RSB: b+~a+1. RSC: b+~a+C.
  - CMN: a+b.
- Flag rules:
  - Arithmetic ops: N=res[WIDTH-1]; Z=(res==0); C=carry-out of the WIDTH-bit add (subtract yields NOT borrow); V=signed overflow (operand sign bits of the adder inputs equal and differ from the result sign).
  - Logical ops and MOV/MVN: N and Z from the result; C and V unchanged.
  - MUL: N and Z from the low WIDTH bits; C and V unchanged.
- Flag write enable: TST/TEQ/CMP/CMN always update flags, ignoring set_flags. Other defined ops update only if set_flags==1.
- Undefined opcodes: result=0, writeback=0, out_valid=1 (consumed normally), flags unchanged.
- Carry-in dependency: the C value used by an accepted ADC/SBC/RSC is the flag register at the accept edge. An op accepted on the cycle after a flag-setting op therefore sees the updated C; no bypass is needed.
- MUL FSM:
  - IDLE -> MUL on accept of 10000. busy=1 and in_ready=0 while in MUL.
  - Shift-add 1 bit per cycle for WIDTH cycles; low WIDTH bits of the product are kept.
  - MUL -> IDLE on the last step. result is registered and out_valid=1 at that edge. Total latency is WIDTH cycles.
  - A MUL cannot be accepted while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL FSM, counter and accumulator are present, and opcode 10000 behaves as above.
- Undefined: no multiplier logic, busy tied 0, FSM stays IDLE. Opcode 10000 is treated as undefined (result=0, writeback=0, flags unchanged, 1-cycle latency).

Test Plan:
- Reset, then ADD with set_flags=1, data1=3, data2=7 -> next cycle result=10, writeback=1, flags=4'b0000.
- CMP data1=5, data2=5 with set_flags=0 -> result=0, writeback=0, flags Z=1, C=1, N=0, V=0 (4'b0011).
- ADDS 0x7FFFFFFF+1 -> result=0x80000000, N=1, V=1, C=0 (4'b1100). Then ADDS 0xFFFFFFFF+1 -> result=0, Z=1, C=1 (4'b0011). Then ADC 2+3 accepted next cycle -> result=6.
- Hold out_ready=0 after an ORR of 0xF0 and 0x0F -> result=0xFF held and in_ready=0. Raise out_ready together with in_valid for EOR 0xFF,0x0F -> pop and accept on the same edge; next result=0xF0.
- MUL (ALU_MUL_EN) data1=-3, data2=7 -> busy=1 and in_ready=0 for 32 cycles, then result=0xFFFFFFEB. With set_flags=1: N=1, C and V unchanged. Assert reset mid-multiply -> all outputs return to reset values.
- Undefined opcode 10011 -> out_valid=1, result=0, writeback=0, flags unchanged from the previous value.

Source files
------------

// File: rtl/pipelined_flag_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_flag_alu
// Description : Registered ARM data-processing ALU with an NZCV flag register,
//               valid/ready handshake and a one-entry output register.
//               Non-multiply ops complete in one cycle. Defining ALU_MUL_EN
//               adds an iterative shift-add multiplier for opcode 10000,
//               which takes WIDTH cycles. With ALU_MUL_EN undefined, opcode
//               10000 is treated as an undefined opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_flag_alu #(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [4:0]       operation,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             writeback,
    output logic [3:0]       flags,
    output logic             busy
);

    // Opcode encodings
    localparam logic [4:0] c_op_and = 5'b00000;
    localparam logic [4:0] c_op_eor = 5'b00001;
    localparam logic [4:0] c_op_sub = 5'b00010;
    localparam logic [4:0] c_op_rsb = 5'b00011;
    localparam logic [4:0] c_op_add = 5'b00100;
    localparam logic [4:0] c_op_adc = 5'b00101;
    localparam logic [4:0] c_op_sbc = 5'b00110;
    localparam logic [4:0] c_op_rsc = 5'b00111;
    localparam logic [4:0] c_op_tst = 5'b01000;
    localparam logic [4:0] c_op_teq = 5'b01001;
    localparam logic [4:0] c_op_cmp = 5'b01010;
    localparam logic [4:0] c_op_cmn = 5'b01011;
    localparam logic [4:0] c_op_orr = 5'b01100;
    localparam logic [4:0] c_op_mov = 5'b01101;
    localparam logic [4:0] c_op_bic = 5'b01110;
    localparam logic [4:0] c_op_mvn = 5'b01111;

    // Flag register bit positions: {V, N, C, Z}
    localparam int c_fz = 0;
    localparam int c_fc = 1;
    localparam int c_fn = 2;
    localparam int c_fv = 3;

    // ------------------------------------------------------------------
    // Registered state behind the output ports
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_writeback;
    logic [3:0]       r_flags;

    // Multiplier interface (tied off when the multiplier is not built)
    logic             w_idle;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;
    logic             w_mul_sf;

    // Handshake
    logic w_accept;

    assign in_ready  = w_idle && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign writeback = r_writeback;
    assign flags     = r_flags;

    // ------------------------------------------------------------------
    // Opcode decode: adder operand selection and logical results
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic             w_is_arith;
    logic             w_is_logic;
    logic             w_is_cmp;
    logic [WIDTH-1:0] w_logic_res;

    // Select adder inputs and carry-in; subtraction is x + ~y + cin so the
    // carry-out directly gives ARM's NOT-borrow convention.
    always_comb begin
        w_add_x     = data1;
        w_add_y     = data2;
        w_add_cin   = 1'b0;
        w_is_arith  = 1'b0;
        w_is_logic  = 1'b0;
        w_is_cmp    = 1'b0;
        w_logic_res = '0;
        case (operation)
            c_op_and: begin
                w_is_logic  = 1'b1;
                w_logic_res = data1 & data2;
            end
            c_op_eor: begin
                w_is_logic  = 1'b1;
                w_logic_res = data1 ^ data2;
            end
            c_op_sub: begin
                w_is_arith = 1'b1;
                w_add_y    = ~data2;
                w_add_cin  = 1'b1;
            end
            c_op_rsb: begin
                w_is_arith = 1'b1;
                w_add_x    = data2;
                w_add_y    = ~data1;
                w_add_cin  = 1'b1;
            end
            c_op_add: begin
                w_is_arith = 1'b1;
            end
            c_op_adc: begin
                w_is_arith = 1'b1;
                w_add_cin  = r_flags[c_fc];
            end
            c_op_sbc: begin
                w_is_arith = 1'b1;
                w_add_y    = ~data2;
                w_add_cin  = r_flags[c_fc];
            end
            c_op_rsc: begin
                w_is_arith = 1'b1;
                w_add_x    = data2;
                w_add_y    = ~data1;
                w_add_cin  = r_flags[c_fc];
            end
            c_op_tst: begin
                w_is_logic  = 1'b1;
                w_is_cmp    = 1'b1;
                w_logic_res = data1 & data2;
            end
            c_op_teq: begin
                w_is_logic  = 1'b1;
                w_is_cmp    = 1'b1;
                w_logic_res = data1 ^ data2;
            end
            c_op_cmp: begin
                w_is_arith = 1'b1;
                w_is_cmp   = 1'b1;
                w_add_y    = ~data2;
                w_add_cin  = 1'b1;
            end
            c_op_cmn: begin
                w_is_arith = 1'b1;
                w_is_cmp   = 1'b1;
            end
            c_op_orr: begin
                w_is_logic  = 1'b1;
                w_logic_res = data1 | data2;
            end
            c_op_mov: begin
                w_is_logic  = 1'b1;
                w_logic_res = data2;
            end
            c_op_bic: begin
                w_is_logic  = 1'b1;
                w_logic_res = data1 & ~data2;
            end
            c_op_mvn: begin
                w_is_logic  = 1'b1;
                w_logic_res = ~data2;
            end
            default: begin
                // Undefined opcode (and MUL, which is handled separately):
                // no result, no writeback, no flag update.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared (WIDTH+1)-bit adder and flag generation
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_wb;
    logic             w_flags_we;
    logic [3:0]       w_alu_flags;

    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_ovf = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                   (w_sum[WIDTH-1]   != w_add_x[WIDTH-1]);

    // Form the single-cycle result, writeback strobe and candidate flags;
    // logical ops keep C and V from the flag register.
    always_comb begin
        w_alu_res   = '0;
        w_alu_wb    = 1'b0;
        w_flags_we  = 1'b0;
        w_alu_flags = r_flags;
        if (w_is_arith) begin
            w_alu_res = w_sum[WIDTH-1:0];
        end else if (w_is_logic) begin
            w_alu_res = w_logic_res;
        end
        if (w_is_arith || w_is_logic) begin
            w_alu_wb         = !w_is_cmp;
            w_flags_we       = w_is_cmp || set_flags;
            w_alu_flags[c_fz] = (w_alu_res == '0);
            w_alu_flags[c_fn] = w_alu_res[WIDTH-1];
            if (w_is_arith) begin
                w_alu_flags[c_fc] = w_sum[WIDTH];
                w_alu_flags[c_fv] = w_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional iterative multiplier
    // ------------------------------------------------------------------
`ifdef ALU_MUL_EN
    localparam logic [4:0]           c_op_mul   = 5'b10000;
    localparam logic [MUL_CNT_W-1:0] c_mul_last = MUL_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } mul_state_t;

    mul_state_t           r_state;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_mul_sf;
    logic                 r_busy;
    logic [WIDTH-1:0]     w_acc_next;

    assign w_is_mul      = (operation == c_op_mul);
    assign w_idle        = (r_state == S_IDLE);
    assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done    = (r_state == S_MUL) && (r_cnt == c_mul_last);
    assign w_mul_product = w_acc_next;
    assign w_mul_sf      = r_mul_sf;
    assign busy          = r_busy;

    // Multiply FSM: load operands on accept, then one shift-add step per
    // cycle; only the low WIDTH product bits are ever accumulated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mul_sf <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state  <= S_MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= data1;
                        r_mplier <= data2;
                        r_mul_sf <= set_flags;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_mul_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_is_mul      = 1'b0;
    assign w_idle        = 1'b1;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
    assign w_mul_sf      = 1'b0;
    assign busy          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output register and flag register
    // ------------------------------------------------------------------
    // Capture single-cycle results or a finished product into the one-entry
    // output register; hold it until popped, and keep flags in step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_writeback <= 1'b0;
            r_flags     <= 4'b0000;
        end else begin
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_result    <= w_alu_res;
                r_writeback <= w_alu_wb;
                if (w_flags_we) begin
                    r_flags <= w_alu_flags;
                end
            end else if (w_accept) begin
                // Multiply accepted: any held output was popped this edge.
                r_out_valid <= 1'b0;
            end else if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_mul_product;
                r_writeback <= 1'b1;
                if (w_mul_sf) begin
                    r_flags[c_fz] <= (w_mul_product == '0);
                    r_flags[c_fn] <= w_mul_product[WIDTH-1];
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_flag_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_flag_alu
// Description : Scoreboard bench for pipelined_flag_alu (WIDTH=32). Expected
//               results are modelled with wide signed/unsigned arithmetic and
//               popped when the DUT presents an output that is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_flag_alu;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data1;
    logic [W-1:0]  data2;
    logic [4:0]    operation;
    logic          set_flags;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          writeback;
    logic [3:0]    flags;
    logic          busy;

    pipelined_flag_alu #(.WIDTH(W), .MUL_CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .operation (operation),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .writeback (writeback),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         wb;
        logic [3:0]   fl;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_flags;
    int         checks;
    int         errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {C, V, result} of x + y + ci
    function automatic logic [W+1:0] f_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [63:0] full;
        longint      s;
        logic        v;
        full = {32'b0, x} + {32'b0, y} + 64'(ci);
        s    = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        v    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {full > 64'hFFFF_FFFF, v, full[W-1:0]};
    endfunction

    // {C, V, result} of x - y - bw, C meaning "no borrow"
    function automatic logic [W+1:0] f_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bw);
        logic [W-1:0] r;
        longint       s;
        logic         v;
        logic         c;
        c = ({32'b0, x} >= ({32'b0, y} + 64'(bw)));
        r = x - y - W'(bw);
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(bw);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {c, v, r};
    endfunction

    task automatic model_push(input logic [4:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic sf);
        exp_t         e;
        logic [W-1:0] r;
        logic [W+1:0] t;
        logic         c;
        logic         v;
        logic         defined;
        logic         is_cmp;
        c       = m_flags[1];
        v       = m_flags[3];
        r       = '0;
        defined = 1'b1;
        is_cmp  = (op == 5'd8) || (op == 5'd9) || (op == 5'd10) || (op == 5'd11);
        t       = '0;
        case (op)
            5'd0, 5'd8:  r = a & b;
            5'd1, 5'd9:  r = a ^ b;
            5'd12:       r = a | b;
            5'd13:       r = b;
            5'd14:       r = a & ~b;
            5'd15:       r = ~b;
            5'd4, 5'd11: t = f_add(a, b, 1'b0);
            5'd5:        t = f_add(a, b, m_flags[1]);
            5'd2, 5'd10: t = f_sub(a, b, 1'b0);
            5'd3:        t = f_sub(b, a, 1'b0);
            5'd6:        t = f_sub(a, b, !m_flags[1]);
            5'd7:        t = f_sub(b, a, !m_flags[1]);
`ifdef ALU_MUL_EN
            5'd16:       r = a * b;
`endif
            default:     defined = 1'b0;
        endcase
        if (op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11}) begin
            {c, v, r} = t;
        end
        if (defined && (is_cmp || sf)) begin
            m_flags = {v, r[W-1], c, (r == '0)};
        end
        e.res = defined ? r : '0;
        e.wb  = defined && !is_cmp;
        e.fl  = m_flags;
        sb_q.push_back(e);
    endtask

    // Present one operation, wait (bounded) for acceptance, record expectation
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sf);
        int n;
        in_valid  = 1'b1;
        operation = op;
        data1     = a;
        data2     = b;
        set_flags = sf;
        n         = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_push(op, a, b, sf);
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard: compare each output as it is consumed
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", 64'(result), 64'(e.res));
                check("sb_writeback", 64'(writeback), 64'(e.wb));
                check("sb_flags", 64'(flags), 64'(e.fl));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] prev_flags;
        int         n;
        checks    = 0;
        errors    = 0;
        m_flags   = 4'b0000;
        reset     = 1'b0;
        in_valid  = 1'b0;
        data1     = '0;
        data2     = '0;
        operation = '0;
        set_flags = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_writeback", 64'(writeback), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // ADDS 3 + 7
        issue(5'd4, 32'd3, 32'd7, 1'b1);
        @(negedge clk);
        check("adds_result", 64'(result), 64'd10);
        check("adds_flags", 64'(flags), 64'h0);
        @(posedge clk); #1;

        // CMP 5,5 without S: flags still update
        issue(5'd10, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        check("cmp_writeback", 64'(writeback), 64'd0);
        check("cmp_flags", 64'(flags), 64'b0011);
        @(posedge clk); #1;

        // Overflow, carry, then ADC using the new carry back-to-back
        issue(5'd4, 32'h7FFF_FFFF, 32'd1, 1'b1);
        @(negedge clk);
        check("adds_ovf_flags", 64'(flags), 64'b1100);
        @(posedge clk); #1;
        issue(5'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(5'd5, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        check("adc_carry_result", 64'(result), 64'd6);
        @(posedge clk); #1;

        // Output hold with out_ready low, then pop and accept on one edge
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        issue(5'd12, 32'hF0, 32'h0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'hFF);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(5'd1, 32'hFF, 32'h0F, 1'b0);
        @(negedge clk);
        check("pop_accept_result", 64'(result), 64'hF0);
        @(posedge clk); #1;

        // Undefined opcode leaves flags alone
        prev_flags = m_flags;
        issue(5'b10011, 32'h1234, 32'h5678, 1'b1);
        @(negedge clk);
        check("undef_valid", 64'(out_valid), 64'd1);
        check("undef_result", 64'(result), 64'd0);
        check("undef_writeback", 64'(writeback), 64'd0);
        check("undef_flags", 64'(flags), 64'(prev_flags));
        @(posedge clk); #1;

`ifdef ALU_MUL_EN
        // MUL -3 * 7 with S
        prev_flags = m_flags;
        issue(5'b10000, 32'hFFFF_FFFD, 32'd7, 1'b1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("mul_busy", 64'(busy), 64'd1);
            check("mul_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        check("mul_done_busy", 64'(busy), 64'd0);
        check("mul_done_valid", 64'(out_valid), 64'd1);
        check("mul_result", 64'(result), 64'hFFFF_FFEB);
        check("mul_flags", 64'(flags), 64'({prev_flags[3], 1'b1, prev_flags[1], 1'b0}));
        @(posedge clk); #1;
`else
        // Without the multiplier, opcode 10000 is undefined with 1-cycle latency
        prev_flags = m_flags;
        issue(5'b10000, 32'hFFFF_FFFD, 32'd7, 1'b1);
        @(negedge clk);
        check("nomul_valid", 64'(out_valid), 64'd1);
        check("nomul_result", 64'(result), 64'd0);
        check("nomul_flags", 64'(flags), 64'(prev_flags));
        check("nomul_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
`endif

        // Randomised traffic with occasional back-pressure
        for (int k = 0; k < 60; k++) begin
            logic [4:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           r;
            r  = int'($urandom_range(0, 19));
            op = (r < 16) ? 5'(r) : 5'(17 + 4 * (r - 16));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
            issue(op, a, b, 1'($urandom_range(0, 1)));
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end

`ifdef ALU_MUL_EN
        // Reset in the middle of a multiply
        issue(5'b10000, 32'd5, 32'd6, 1'b1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        sb_q.delete();
        m_flags = 4'b0000;
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_result", 64'(result), 64'd0);
        check("mrst_flags", 64'(flags), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        issue(5'd4, 32'd1, 32'd1, 1'b1);
`endif

        // Drain the scoreboard
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
